// File: rtl/latency_injector.sv
// Per-channel programmable latency stage. Each channel holds one payload for a
// captured number of cycles, then presents it until the downstream accepts it.
module latency_injector #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_DELAY    = 15,
    localparam int CW          = $clog2(MAX_DELAY + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CHANNELS-1:0]          in_valid,
    output logic [NUM_CHANNELS-1:0]          in_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS*CW-1:0]       cfg_delay,
    input  logic [NUM_CHANNELS-1:0]          cfg_bypass,
    output logic [NUM_CHANNELS-1:0]          out_valid,
    input  logic [NUM_CHANNELS-1:0]          out_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CHANNELS-1:0]          busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        state_t                state_reg;
        logic [CW-1:0]         cnt_reg;
        logic [DATA_WIDTH-1:0] data_reg;
        logic [CW-1:0]         delay_in;
        logic [CW-1:0]         delay_eff;
        logic [DATA_WIDTH-1:0] data_in;
        logic                  idle;
        logic                  present;
        logic                  bypass_pass;
        logic                  accept;

        assign delay_in = cfg_delay[gi*CW +: CW];
        assign data_in  = in_data[gi*DATA_WIDTH +: DATA_WIDTH];

        // Clamping only exists when the delay field can encode values above MAX_DELAY.
        if (((1 << CW) - 1) > MAX_DELAY) begin : g_clamp
            localparam logic [CW-1:0] MAX_D = CW'(MAX_DELAY);
            assign delay_eff = (delay_in > MAX_D) ? MAX_D : delay_in;
        end else begin : g_noclamp
            assign delay_eff = delay_in;
        end

        assign idle        = (state_reg == IDLE);
        assign present     = (state_reg == PRESENT);
        assign bypass_pass = rst_n & idle & cfg_bypass[gi] & in_valid[gi];
        assign accept      = idle & ~cfg_bypass[gi] & in_valid[gi];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                data_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            data_reg <= data_in;
                            if (delay_eff == '0) begin
                                state_reg <= PRESENT;
                                cnt_reg   <= '0;
                            end else begin
                                state_reg <= COUNT;
                                cnt_reg   <= delay_eff - 1'b1;
                            end
                        end
                    end
                    COUNT: begin
                        if (cnt_reg == '0) begin
                            state_reg <= PRESENT;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    PRESENT: begin
                        if (out_ready[gi]) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end

        // Outputs are forced quiet while reset is held, independent of the stored state.
        assign in_ready[gi]  = rst_n ? (idle & (cfg_bypass[gi] ? out_ready[gi] : 1'b1))
                                     : ~cfg_bypass[gi];
        assign out_valid[gi] = (rst_n & present) | bypass_pass;
        assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] =
            (rst_n & present) ? data_reg :
            bypass_pass       ? data_in  : '0;
        assign busy[gi]      = rst_n & ~idle;
    end

endmodule

// File: tb/tb_latency_injector.sv
// Directed bench for latency_injector: latency, clamping, backpressure, bypass,
// concurrency and reset abort, with hand-computed expectations.
module tb_latency_injector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid, in_ready, cfg_bypass, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    logic [15:0]  cfg_delay;

    // Second instance with a non power-of-two MAX_DELAY to exercise clamping.
    logic         d2_in_valid, d2_in_ready, d2_cfg_bypass, d2_out_valid, d2_out_ready, d2_busy;
    logic [7:0]   d2_in_data, d2_out_data;
    logic [3:0]   d2_cfg_delay;

    int checks = 0;
    int failures = 0;

    latency_injector #(.NUM_CHANNELS(4), .DATA_WIDTH(32), .MAX_DELAY(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cfg_delay  (cfg_delay),
        .cfg_bypass (cfg_bypass),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    latency_injector #(.NUM_CHANNELS(1), .DATA_WIDTH(8), .MAX_DELAY(10)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (d2_in_valid),
        .in_ready   (d2_in_ready),
        .in_data    (d2_in_data),
        .cfg_delay  (d2_cfg_delay),
        .cfg_bypass (d2_cfg_bypass),
        .out_valid  (d2_out_valid),
        .out_ready  (d2_out_ready),
        .out_data   (d2_out_data),
        .busy       (d2_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [3:0] dly, input logic [31:0] data);
        in_valid[ch] = 1'b1;
        cfg_delay[ch*4 +: 4] = dly;
        in_data[ch*32 +: 32] = data;
        tick();
        in_valid[ch] = 1'b0;
    endtask

    // Returns cycles from the acceptance edge to first out_valid; capped at 40.
    task automatic wait_valid(input int ch, output int lat);
        lat = 1;
        while (!out_valid[ch] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic d2_measure(input logic [3:0] dly, output int lat);
        d2_cfg_delay = dly;
        d2_in_valid  = 1'b1;
        tick();
        d2_in_valid  = 1'b0;
        lat = 1;
        while (!d2_out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [3:0] exp_v;

        rst_n      = 1'b0;
        in_valid   = 4'b0010;
        in_data    = '0;
        in_data[63:32] = 32'h5555_0001;
        cfg_delay  = '0;
        cfg_bypass = 4'b0010;
        out_ready  = 4'b0000;
        d2_in_valid = 1'b0; d2_in_data = 8'h3C; d2_cfg_delay = 4'd0;
        d2_cfg_bypass = 1'b0; d2_out_ready = 1'b1;
        tick();
        tick();

        // Reset state, including a bypass channel with in_valid high
        check_eq("rst_out_valid", out_valid, 4'b0000);
        check_eq("rst_out_data", (out_data != '0), 1'b0);
        check_eq("rst_busy", busy, 4'b0000);
        check_eq("rst_in_ready", in_ready, 4'b1101);
        check_eq("rst_d2_idle", {d2_busy, d2_out_valid, d2_in_ready}, 3'b001);

        rst_n = 1'b1;
        in_valid = 4'b0000;
        cfg_bypass = 4'b0000;
        out_ready = 4'b1111;
        tick();
        check_eq("idle_in_ready", in_ready, 4'b1111);

        // Delay 3 on channel 0: valid only at t+4, busy t+1..t+4
        send(0, 4'd3, 32'hA5A5_A5A5);
        for (int k = 1; k <= 5; k++) begin
            check_eq($sformatf("d3_valid_k%0d", k), out_valid[0], (k == 4));
            check_eq($sformatf("d3_busy_k%0d", k), busy[0], (k <= 4));
            if (k == 4) check_eq("d3_data", out_data[31:0], 32'hA5A5_A5A5);
            if (k == 2) check_eq("d3_data_zero", out_data[31:0], 32'h0);
            if (k == 2) check_eq("d3_in_ready_busy", in_ready[0], 1'b0);
            tick();
        end
        $display("txn ch=0 delay=3 data=a5a5a5a5");

        // Delay 0 and maximum delay
        send(0, 4'd0, 32'h0000_0D00);
        wait_valid(0, lat);
        check_eq("d0_latency", lat, 1);
        check_eq("d0_data", out_data[31:0], 32'h0000_0D00);
        $display("txn ch=0 delay=0 lat=%0d", lat);
        tick();
        send(0, 4'd15, 32'h0000_0F0F);
        wait_valid(0, lat);
        check_eq("d15_latency", lat, 16);
        $display("txn ch=0 delay=15 lat=%0d", lat);
        tick();

        // Clamp on the MAX_DELAY=10 instance
        d2_measure(4'd15, lat);
        check_eq("clamp_latency", lat, 11);
        check_eq("clamp_data", d2_out_data, 8'h3C);
        $display("txn d2 delay=15 lat=%0d", lat);
        tick();
        d2_measure(4'd7, lat);
        check_eq("d2_d7_latency", lat, 8);
        $display("txn d2 delay=7 lat=%0d", lat);
        tick();

        // Backpressure on channel 2
        out_ready[2] = 1'b0;
        send(2, 4'd2, 32'hC0DE_0002);
        wait_valid(2, lat);
        check_eq("bp_latency", lat, 3);
        in_data[95:64] = 32'hFFFF_0000;
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("bp_valid_%0d", k), out_valid[2], 1'b1);
            check_eq($sformatf("bp_data_%0d", k), out_data[95:64], 32'hC0DE_0002);
            check_eq($sformatf("bp_in_ready_%0d", k), in_ready[2], 1'b0);
            tick();
        end
        out_ready[2] = 1'b1;
        #1;
        check_eq("bp_hs_in_ready", in_ready[2], 1'b0);
        tick();
        check_eq("bp_after_in_ready", in_ready[2], 1'b1);
        check_eq("bp_after_valid", out_valid[2], 1'b0);
        $display("txn ch=2 delay=2 backpressure");

        // Bypass on channel 1
        cfg_bypass[1] = 1'b1;
        in_data[63:32] = 32'h1234_5678;
        in_valid[1] = 1'b1;
        out_ready[1] = 1'b0;
        #1;
        check_eq("byp_valid", out_valid[1], 1'b1);
        check_eq("byp_data", out_data[63:32], 32'h1234_5678);
        check_eq("byp_in_ready_lo", in_ready[1], 1'b0);
        check_eq("byp_busy", busy[1], 1'b0);
        out_ready[1] = 1'b1;
        #1;
        check_eq("byp_in_ready_hi", in_ready[1], 1'b1);
        tick();
        check_eq("byp_busy_after", busy[1], 1'b0);
        in_valid[1] = 1'b0;
        #1;
        check_eq("byp_valid_off", out_valid[1], 1'b0);
        check_eq("byp_data_off", out_data[63:32], 32'h0);
        cfg_bypass[1] = 1'b0;
        #1;
        check_eq("byp_exit_in_ready", in_ready[1], 1'b1);
        $display("txn ch=1 bypass");

        // Bypass and delay changes during an in-flight count
        send(3, 4'd3, 32'h3333_0003);
        cfg_bypass[3] = 1'b1;
        in_valid[3] = 1'b1;
        in_data[127:96] = 32'h0000_0BAD;
        cfg_delay[15:12] = 4'd9;
        wait_valid(3, lat);
        check_eq("inflight_latency", lat, 4);
        check_eq("inflight_data", out_data[127:96], 32'h3333_0003);
        check_eq("inflight_busy", busy[3], 1'b1);
        tick();
        check_eq("inflight_then_byp_busy", busy[3], 1'b0);
        check_eq("inflight_then_byp_data", out_data[127:96], 32'h0000_0BAD);
        in_valid[3] = 1'b0;
        cfg_bypass[3] = 1'b0;
        $display("txn ch=3 delay=3 lat=%0d bypass-midflight", lat);
        tick();

        // Concurrency: delays 1..4 accepted together
        cfg_delay = {4'd4, 4'd3, 4'd2, 4'd1};
        in_data = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        in_valid = 4'b1111;
        tick();
        in_valid = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            exp_v = 4'b0000;
            for (int i = 0; i < 4; i++) if (k == i + 2) exp_v[i] = 1'b1;
            check_eq($sformatf("conc_valid_k%0d", k), out_valid, exp_v);
            tick();
        end
        $display("txn ch=0..3 delays=1,2,3,4 concurrent");

        // Reset mid-count
        send(0, 4'd10, 32'hDEAD_0010);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rstmid_busy", busy[0], 1'b0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid[0]) seen = 1;
            tick();
        end
        check_eq("rstmid_no_valid", seen, 0);
        send(0, 4'd2, 32'h0000_BEEF);
        wait_valid(0, lat);
        check_eq("rstmid_new_latency", lat, 3);
        check_eq("rstmid_new_data", out_data[31:0], 32'h0000_BEEF);
        $display("txn ch=0 delay=10 aborted, then delay=2 lat=%0d", lat);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
